// File: rtl/uart_tx_telemetria.sv
// Telemetry UART transmitter: buffers status words in a FIFO and sends each one as SYNC + NBYTES data bytes.
// Pop-to-start-bit is 1 cycle; writes into a full FIFO are dropped and flagged in the sticky overflow output.

module telem_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // A push is refused on full even if a pop happens in the same cycle.
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module uart_tx_telemetria #(
    parameter int         DATA_W     = 14,
    parameter int         FIFO_DEPTH = 4,
    parameter int         BAUD_DIV   = 434,
    parameter int         PARITY     = 0,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         EDGE_MODE  = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               i_data,
    input  logic                            wr,
    input  logic                            clr_ovf,
    output logic                            s_out,
    output logic                            busy,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int   NBYTES   = (DATA_W + 7) / 8;
    localparam int   WORD_W   = NBYTES * 8;
    localparam int   STOP_LEN = STOP_BITS * BAUD_DIV;
    localparam int   BW       = $clog2(STOP_LEN + 1);
    localparam int   BYW      = $clog2(NBYTES + 1);
    localparam logic PAR_ODD  = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAR   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYW-1:0]    byte_q, byte_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        sh_q, sh_d;
    logic              so_q, so_d;
    logic              busy_q, busy_d;
    logic              wr_q;
    logic              ovf_q, ovf_d;

    logic              wr_req;
    logic              pop;
    logic [DATA_W-1:0] head_dat;
    logic              full;
    logic              baud_end;

    assign wr_req = (EDGE_MODE != 0) ? (wr & ~wr_q) : wr;
    assign ovf_d  = (wr_req & full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    telem_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (wr_req),
        .push_dat (i_data),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .full     (full),
        .count    (fifo_count)
    );

    assign baud_end = (baud_q == BW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        sh_d    = sh_q;
        so_d    = so_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                so_d   = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    word_d  = WORD_W'(head_dat);
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sh_d    = SYNC_BYTE;
                byte_d  = '0;
                baud_d  = '0;
                so_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    so_d    = sh_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            so_d    = (^sh_q) ^ PAR_ODD;
                            state_d = S_PAR;
                        end else begin
                            so_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        so_d  = sh_q[bit_q + 3'd1];
                    end
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    baud_d  = '0;
                    so_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                so_d = 1'b1;
                // The last stop bit ends one cycle early so the LOAD cycle overlaps it; back-to-back packets stay gapless.
                if (byte_q == BYW'(NBYTES)) begin
                    if (baud_q == BW'(STOP_LEN - 2)) begin
                        baud_d = '0;
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            word_d  = WORD_W'(head_dat);
                            state_d = S_LOAD;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (baud_q == BW'(STOP_LEN - 1)) begin
                    baud_d  = '0;
                    byte_d  = byte_q + BYW'(1);
                    sh_d    = word_q[WORD_W-1 -: 8];
                    word_d  = word_q << 8;
                    so_d    = 1'b0;
                    state_d = S_START;
                end
            end
            default: begin
                so_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            sh_q    <= '0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            wr_q    <= wr;
            ovf_q   <= ovf_d;
        end
    end

    assign s_out     = so_q;
    assign busy      = busy_q;
    assign fifo_full = full;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx_telemetria.sv
// Bench for uart_tx_telemetria: four instances (edge/level write mode, no/even/odd parity), BAUD_DIV=4.
// Serial frames are decoded mid-bit on the falling clock edge and compared with hand-computed bytes.

module tb_uart_tx_telemetria;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]       rst, wr, clr, so, bsy, full, ovf;
    logic [3:0][13:0] dat;
    logic [3:0][2:0]  cnt;

    int checks   = 0;
    int failures = 0;

    // 0: edge mode, no parity; 1: level mode, no parity; 2: even parity; 3: odd parity
    uart_tx_telemetria #(.DATA_W(14), .FIFO_DEPTH(4), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1), .SYNC_BYTE(8'hA5), .EDGE_MODE(1))
        u_a (.clock(clock), .reset(rst[0]), .i_data(dat[0]), .wr(wr[0]), .clr_ovf(clr[0]), .s_out(so[0]),
             .busy(bsy[0]), .fifo_full(full[0]), .fifo_count(cnt[0]), .overflow(ovf[0]));
    uart_tx_telemetria #(.DATA_W(14), .FIFO_DEPTH(4), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1), .SYNC_BYTE(8'hA5), .EDGE_MODE(0))
        u_b (.clock(clock), .reset(rst[1]), .i_data(dat[1]), .wr(wr[1]), .clr_ovf(clr[1]), .s_out(so[1]),
             .busy(bsy[1]), .fifo_full(full[1]), .fifo_count(cnt[1]), .overflow(ovf[1]));
    uart_tx_telemetria #(.DATA_W(14), .FIFO_DEPTH(4), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1), .SYNC_BYTE(8'hA5), .EDGE_MODE(1))
        u_e (.clock(clock), .reset(rst[2]), .i_data(dat[2]), .wr(wr[2]), .clr_ovf(clr[2]), .s_out(so[2]),
             .busy(bsy[2]), .fifo_full(full[2]), .fifo_count(cnt[2]), .overflow(ovf[2]));
    uart_tx_telemetria #(.DATA_W(14), .FIFO_DEPTH(4), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1), .SYNC_BYTE(8'hA5), .EDGE_MODE(1))
        u_o (.clock(clock), .reset(rst[3]), .i_data(dat[3]), .wr(wr[3]), .clr_ovf(clr[3]), .s_out(so[3]),
             .busy(bsy[3]), .fifo_full(full[3]), .fifo_count(cnt[3]), .overflow(ovf[3]));

    typedef struct {
        int          d;
        logic [13:0] din;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [2:0]  epar;   // bit0 = parity of sync byte, bit2 = parity of last byte
    } vec_t;

    vec_t        tbl [7];
    logic [7:0]  rxb [15];
    logic        rxp [15];
    bit          rxok [15];
    logic [13:0] dseq [6];
    int          pk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns sampled at the middle of the stop bit; a following contiguous start bit is 3 cycles later.
    task automatic rx_byte(input int d, input bit search, input bit has_par,
                           output logic [7:0] b, output logic pb, output bit ok);
        int n;
        ok = 1'b1;
        b  = '0;
        pb = 1'b0;
        if (search) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (so[d] !== 1'b0 && n < 600);
            if (so[d] !== 1'b0) ok = 1'b0;
        end else begin
            repeat (3) @(negedge clock);
            if (so[d] !== 1'b0) ok = 1'b0;
        end
        @(negedge clock);
        if (so[d] !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clock);
            b[i] = so[d];
        end
        if (has_par) begin
            repeat (4) @(negedge clock);
            pb = so[d];
        end
        repeat (4) @(negedge clock);
        if (so[d] !== 1'b1) ok = 1'b0;
    endtask

    task automatic pulse(input int d, input logic [13:0] v);
        @(posedge clock);
        #1;
        dat[d] = v;
        wr[d]  = 1'b1;
        @(posedge clock);
        #1;
        wr[d]  = 1'b0;
    endtask

    task automatic quiet(input int d, input int cyc, output int act);
        act = 0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clock);
            if (so[d] !== 1'b1 || bsy[d] !== 1'b0) act++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  b0, b1, b2;
        logic        p0, p1, p2;
        bit          k0, k1, k2;
        int          n, bn, act, bad;
        logic [13:0] tmp;

        rst = '1; wr = '0; clr = '0; dat = '0;
        tbl[0] = '{0, 14'h2A5B, 8'h2A, 8'h5B, 3'b000};
        tbl[1] = '{0, 14'h3FFF, 8'h3F, 8'hFF, 3'b000};
        tbl[2] = '{0, 14'h0000, 8'h00, 8'h00, 3'b000};
        tbl[3] = '{2, 14'h002A, 8'h00, 8'h2A, 3'b100};
        tbl[4] = '{3, 14'h002A, 8'h00, 8'h2A, 3'b011};
        tbl[5] = '{2, 14'h1234, 8'h12, 8'h34, 3'b100};
        tbl[6] = '{3, 14'h1234, 8'h12, 8'h34, 3'b011};
        dseq[0] = 14'h1A01; dseq[1] = 14'h2B12; dseq[2] = 14'h3C23;
        dseq[3] = 14'h0D34; dseq[4] = 14'h1E45; dseq[5] = 14'h2F56;

        repeat (3) @(posedge clock);
        #1 rst = '0;
        @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst%0d_sout", d), so[d], 1);
            check($sformatf("rst%0d_busy", d), bsy[d], 0);
            check($sformatf("rst%0d_full", d), full[d], 0);
            check($sformatf("rst%0d_count", d), cnt[d], 0);
            check($sformatf("rst%0d_ovf", d), ovf[d], 0);
        end

        // Write-to-start latency and busy duration
        @(posedge clock);
        #1 dat[0] = 14'h2A5B; wr[0] = 1'b1;
        @(posedge clock);
        #1 wr[0] = 1'b0;
        @(negedge clock);
        check("s1_k_sout", so[0], 1);
        check("s1_k_busy", bsy[0], 0);
        check("s1_k_count", cnt[0], 1);
        @(negedge clock);
        check("s1_pop_busy", bsy[0], 1);
        check("s1_pop_count", cnt[0], 0);
        check("s1_pop_sout", so[0], 1);
        @(negedge clock);
        check("s1_start_bit", so[0], 0);
        bn = 2;
        n  = 0;
        while (bsy[0] === 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
            if (bsy[0] === 1'b1) bn++;
        end
        check("s1_busy_len", bn, 120);
        check("s1_idle_sout", so[0], 1);

        for (int r = 0; r < 7; r++) begin
            pulse(tbl[r].d, tbl[r].din);
            rx_byte(tbl[r].d, 1'b1, tbl[r].d >= 2, b0, p0, k0);
            rx_byte(tbl[r].d, 1'b0, tbl[r].d >= 2, b1, p1, k1);
            rx_byte(tbl[r].d, 1'b0, tbl[r].d >= 2, b2, p2, k2);
            check($sformatf("vec%0d_sync", r), b0, 8'hA5);
            check($sformatf("vec%0d_b1", r), b1, tbl[r].e1);
            check($sformatf("vec%0d_b2", r), b2, tbl[r].e2);
            check($sformatf("vec%0d_frame", r), {k0, k1, k2}, 3'b111);
            if (tbl[r].d >= 2) check($sformatf("vec%0d_parity", r), {p2, p1, p0}, tbl[r].epar);
            n = 0;
            while (bsy[tbl[r].d] !== 1'b0 && n < 20) begin
                @(negedge clock);
                n++;
            end
        end

        // Edge mode: wr held high for 10 cycles queues exactly one word
        pk = 0;
        fork
            begin
                @(posedge clock);
                #1 dat[0] = 14'h1357; wr[0] = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clock);
                    if (int'(cnt[0]) > pk) pk = int'(cnt[0]);
                end
                wr[0] = 1'b0;
            end
            begin
                rx_byte(0, 1'b1, 1'b0, b0, p0, k0);
                rx_byte(0, 1'b0, 1'b0, b1, p1, k1);
                rx_byte(0, 1'b0, 1'b0, b2, p2, k2);
            end
        join
        check("s2_peak_count", pk, 1);
        check("s2_ovf", ovf[0], 0);
        check("s2_bytes", {b0, b1, b2}, 24'hA51357);
        check("s2_frame", {k0, k1, k2}, 3'b111);
        quiet(0, 200, act);
        check("s2_single_packet", act, 0);

        // Level mode: 6 consecutive writes, 5 accepted back-to-back, the 6th dropped
        fork
            begin
                @(posedge clock);
                #1 dat[1] = dseq[0]; wr[1] = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clock);
                    #1;
                    if (i < 5) dat[1] = dseq[i+1];
                    else       wr[1]  = 1'b0;
                    @(negedge clock);
                    if (i == 3) check("s3_not_full_c5", full[1], 0);
                    if (i == 4) begin
                        check("s3_full_c6", full[1], 1);
                        check("s3_count_c6", cnt[1], 4);
                        check("s3_ovf_c6", ovf[1], 0);
                    end
                    if (i == 5) begin
                        check("s3_ovf_set", ovf[1], 1);
                        check("s3_count_drop", cnt[1], 4);
                    end
                end
            end
            begin
                for (int j = 0; j < 15; j++) rx_byte(1, j == 0, 1'b0, rxb[j], rxp[j], rxok[j]);
            end
        join
        for (int p = 0; p < 5; p++) begin
            tmp = dseq[p];
            check($sformatf("s3_p%0d_sync", p), rxb[3*p], 8'hA5);
            check($sformatf("s3_p%0d_hi", p), rxb[3*p+1], {2'b00, tmp[13:8]});
            check($sformatf("s3_p%0d_lo", p), rxb[3*p+2], tmp[7:0]);
        end
        bad = 0;
        for (int j = 0; j < 15; j++) if (!rxok[j]) bad++;
        check("s3_contiguous_frames", bad, 0);
        quiet(1, 200, act);
        check("s3_no_sixth_packet", act, 0);

        // Overflow clear, then clear coinciding with a drop
        check("s6_ovf_sticky", ovf[1], 1);
        @(posedge clock);
        #1 clr[1] = 1'b1;
        @(posedge clock);
        #1 clr[1] = 1'b0;
        @(negedge clock);
        check("s6_clr", ovf[1], 0);
        @(posedge clock);
        #1 dat[1] = 14'h0777; wr[1] = 1'b1;
        repeat (5) @(posedge clock);
        #1 clr[1] = 1'b1;
        @(negedge clock);
        check("s6_full", full[1], 1);
        check("s6_ovf_before", ovf[1], 0);
        @(posedge clock);
        #1 wr[1] = 1'b0; clr[1] = 1'b0;
        @(negedge clock);
        check("s6_set_wins", ovf[1], 1);
        check("s6_count", cnt[1], 4);

        // Reset in the middle of byte 1 with two words queued
        pulse(0, 14'h0111);
        pulse(0, 14'h0222);
        pulse(0, 14'h0333);
        @(negedge clock);
        check("s5_queued", cnt[0], 2);
        check("s5_busy_before", bsy[0], 1);
        repeat (44) @(posedge clock);
        #1 rst[0] = 1'b1;
        @(posedge clock);
        #1 rst[0] = 1'b0;
        @(negedge clock);
        check("s5_sout", so[0], 1);
        check("s5_busy", bsy[0], 0);
        check("s5_count", cnt[0], 0);
        check("s5_full", full[0], 0);
        quiet(0, 300, act);
        check("s5_no_packets", act, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
